// File: rtl/fpnew_opgroup_issue_sched.sv
// -----------------------------------------------------------------------------
// fpnew_opgroup_issue_sched
//
// In-order issue/retire scheduler between the FPU dispatch and its operation
// group blocks. Each accepted operation goes to the group selected by
// in_group_i. Its group index is pushed into an order queue. Only the group at
// the head of that queue gets the single result port, so results retire in
// issue order even when group latencies differ.
//
// Ports
//   clk_i, rst_i         clock, synchronous active-high reset
//   flush_i              drop all in-flight bookkeeping
//   in_valid_i/in_ready_o, in_group_i
//                        operation request, its handshake and its target group
//   grp_in_valid_o/grp_in_ready_i
//                        per-group issue handshake (valid is one-hot)
//   grp_out_valid_i/grp_out_ready_o
//                        per-group result handshake (grant only to the head)
//   grp_result_i, grp_status_i
//                        per-group result and flags, group g at slice g
//   out_valid_o/out_ready_i, result_o, status_o
//                        retired result port
//   outstanding_o, busy_o
//                        occupancy of the order queue
// -----------------------------------------------------------------------------
module fpnew_opgroup_issue_sched #(
    parameter int unsigned NumGroups = 4,
    parameter int unsigned Depth     = 8,
    parameter int unsigned Width     = 32,
    localparam int unsigned GW = $clog2(NumGroups),
    localparam int unsigned CW = $clog2(Depth + 1)
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       flush_i,
    input  logic                       in_valid_i,
    input  logic [GW-1:0]              in_group_i,
    output logic                       in_ready_o,
    output logic [NumGroups-1:0]       grp_in_valid_o,
    input  logic [NumGroups-1:0]       grp_in_ready_i,
    input  logic [NumGroups-1:0]       grp_out_valid_i,
    output logic [NumGroups-1:0]       grp_out_ready_o,
    input  logic [NumGroups*Width-1:0] grp_result_i,
    input  logic [NumGroups*5-1:0]     grp_status_i,
    output logic                       out_valid_o,
    input  logic                       out_ready_i,
    output logic [Width-1:0]           result_o,
    output logic [4:0]                 status_o,
    output logic [CW-1:0]              outstanding_o,
    output logic                       busy_o
);

    localparam int unsigned PW = $clog2(Depth);

    logic [GW-1:0]        order_q [Depth];
    logic [PW-1:0]        wp;
    logic [PW-1:0]        rp;
    logic [CW-1:0]        cnt;

    logic                 full;
    logic                 empty;
    logic                 blocked;
    logic                 can_issue;
    logic                 grant;
    logic                 push;
    logic                 pop;
    logic [GW-1:0]        head;
    logic [NumGroups-1:0] in_sel;
    logic [NumGroups-1:0] head_sel;

    assign full    = (cnt == CW'(Depth));
    assign empty   = (cnt == '0);
    assign blocked = flush_i | rst_i;
    assign head    = order_q[rp];

    // Decoded one-hot selects. An out-of-range group index decodes to all
    // zeros, which keeps both the request and the ready low.
    // head_sel is masked by !empty so a stale queue entry never selects a group.
    always_comb begin
        in_sel   = '0;
        head_sel = '0;
        for (int g = 0; g < int'(NumGroups); g++) begin
            in_sel[g]   = (in_group_i == GW'(g));
            head_sel[g] = !empty && (head == GW'(g));
        end
    end

    // Issue side: full blocks even when a pop happens in the same cycle.
    assign can_issue      = !full & !blocked;
    assign grp_in_valid_o = in_sel & {NumGroups{in_valid_i & can_issue}};
    assign in_ready_o     = (|(in_sel & grp_in_ready_i)) & can_issue;
    assign push           = in_valid_i & in_ready_o;

    // Retire side: head_sel comes from registers only, so the valid path is a
    // single NumGroups-wide AND-OR regardless of Depth.
    assign grant           = out_ready_i & !blocked;
    assign grp_out_ready_o = head_sel & {NumGroups{grant}};
    assign out_valid_o     = (|(head_sel & grp_out_valid_i)) & !blocked;
    assign pop             = out_valid_o & out_ready_i;

    // Result mux; head_sel is all zeros when empty so the outputs read 0.
    always_comb begin
        result_o = '0;
        status_o = '0;
        for (int g = 0; g < int'(NumGroups); g++) begin
            if (head_sel[g]) begin
                result_o = result_o | grp_result_i[g*Width +: Width];
                status_o = status_o | grp_status_i[g*5 +: 5];
            end
        end
    end

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(Depth - 1)) ? '0 : p + PW'(1);
    endfunction

    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            wp  <= '0;
            rp  <= '0;
            cnt <= '0;
        end else begin
            if (push) begin
                wp <= ptr_inc(wp);
            end
            if (pop) begin
                rp <= ptr_inc(rp);
            end
            if (push && !pop) begin
                cnt <= cnt + CW'(1);
            end else if (pop && !push) begin
                cnt <= cnt - CW'(1);
            end
        end
    end

    // Queue storage needs no reset: entries are only read while cnt covers them.
    always_ff @(posedge clk_i) begin
        if (push) begin
            order_q[wp] <= in_group_i;
        end
    end

    assign outstanding_o = cnt;
    assign busy_o        = (cnt != '0);

endmodule

// File: tb/tb_fpnew_opgroup_issue_sched.sv
// -----------------------------------------------------------------------------
// tb_fpnew_opgroup_issue_sched
//
// Bench for fpnew_opgroup_issue_sched with 3 groups (latencies 4, 1 and 2) and
// a 5-entry order queue. Groups are modelled as latency buffers that hold
// their front result until granted. The reference model is a queue of issued
// group indices plus a scoreboard of expected results. Directed phases follow
// the feature list, then a randomized phase runs.
// -----------------------------------------------------------------------------
module tb_fpnew_opgroup_issue_sched;

    localparam int NG    = 3;
    localparam int DEPTH = 5;
    localparam int W     = 32;
    localparam int GW    = 2;
    localparam int CW    = 3;

    logic            clk_i = 1'b0;
    logic            rst_i;
    logic            flush_i;
    logic            in_valid_i;
    logic [GW-1:0]   in_group_i;
    logic            in_ready_o;
    logic [NG-1:0]   grp_in_valid_o;
    logic [NG-1:0]   grp_in_ready_i;
    logic [NG-1:0]   grp_out_valid_i;
    logic [NG-1:0]   grp_out_ready_o;
    logic [NG*W-1:0] grp_result_i;
    logic [NG*5-1:0] grp_status_i;
    logic            out_valid_o;
    logic            out_ready_i;
    logic [W-1:0]    result_o;
    logic [4:0]      status_o;
    logic [CW-1:0]   outstanding_o;
    logic            busy_o;

    always #5 clk_i = ~clk_i;

    fpnew_opgroup_issue_sched #(
        .NumGroups(NG),
        .Depth    (DEPTH),
        .Width    (W)
    ) dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .flush_i        (flush_i),
        .in_valid_i     (in_valid_i),
        .in_group_i     (in_group_i),
        .in_ready_o     (in_ready_o),
        .grp_in_valid_o (grp_in_valid_o),
        .grp_in_ready_i (grp_in_ready_i),
        .grp_out_valid_i(grp_out_valid_i),
        .grp_out_ready_o(grp_out_ready_o),
        .grp_result_i   (grp_result_i),
        .grp_status_i   (grp_status_i),
        .out_valid_o    (out_valid_o),
        .out_ready_i    (out_ready_i),
        .result_o       (result_o),
        .status_o       (status_o),
        .outstanding_o  (outstanding_o),
        .busy_o         (busy_o)
    );

    typedef struct packed {
        logic [W-1:0] res;
        logic [4:0]   st;
    } tok_t;

    int errors = 0;
    int checks = 0;

    // Reference model: in-flight group indices in issue order, and the
    // scoreboard of results expected on the retire port.
    int   hq[$];
    tok_t sb[$];
    int   model_cnt = 0;
    int   cyc = 0;

    // Group environment: per-group ring buffers of results with ready cycle.
    int           lat [NG] = '{4, 1, 2};
    logic [W-1:0] gres[NG][8];
    logic [4:0]   gst [NG][8];
    int           grdy[NG][8];
    int           gh  [NG] = '{0, 0, 0};
    int           gn  [NG] = '{0, 0, 0};

    // Current operand token presented with the request.
    tok_t tok;

    // Events seen at the sampling point, applied at the following edge.
    logic          rec_rst   = 1'b1;
    logic          rec_flush = 1'b0;
    logic          rec_acc   = 1'b0;
    logic          rec_pop   = 1'b0;
    logic [GW-1:0] rec_grp   = '0;
    tok_t          rec_tok   = '0;
    logic [NG-1:0] rec_gacc  = '0;
    logic [NG-1:0] rec_gpop  = '0;

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endfunction

    // Per-cycle checker against the model, sampled on the falling edge.
    always @(negedge clk_i) begin
        logic          blk;
        logic          full;
        logic          ne;
        int            hg;
        logic          eir;
        logic          eov;
        logic [NG-1:0] egv;
        logic [NG-1:0] egr;
        blk  = rst_i | flush_i;
        full = (model_cnt == DEPTH);
        ne   = (hq.size() > 0);
        hg   = ne ? hq[0] : 0;
        eir  = 1'b0;
        if (int'(in_group_i) < NG) eir = grp_in_ready_i[in_group_i];
        eir  = eir & !full & !blk;
        egv  = '0;
        if (in_valid_i && int'(in_group_i) < NG && !full && !blk) egv[in_group_i] = 1'b1;
        egr  = '0;
        eov  = 1'b0;
        if (ne && !blk) begin
            egr[hg] = out_ready_i;
            eov     = grp_out_valid_i[hg];
        end
        chk("in_ready", in_ready_o, eir);
        chk("grp_in_valid", grp_in_valid_o, egv);
        chk("grp_out_ready", grp_out_ready_o, egr);
        chk("out_valid", out_valid_o, eov);
        chk("outstanding", outstanding_o, model_cnt);
        chk("busy", busy_o, model_cnt != 0);
        if (model_cnt == 0) begin
            chk("empty_result", result_o, 0);
            chk("empty_status", status_o, 0);
        end
        rec_rst   = rst_i;
        rec_flush = flush_i;
        rec_acc   = in_valid_i & eir;
        rec_pop   = eov & out_ready_i;
        rec_grp   = in_group_i;
        rec_tok   = tok;
        rec_gacc  = grp_in_valid_o & grp_in_ready_i;
        rec_gpop  = grp_out_valid_i & grp_out_ready_o;
    end

    // Monitor: every retirement the DUT presents is matched to the scoreboard.
    always @(negedge clk_i) begin
        tok_t t;
        if (out_valid_o && out_ready_i) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL retire_unexpected: got result %0h, expected no retirement", result_o);
            end else begin
                t = sb.pop_front();
                chk("retire_result", result_o, t.res);
                chk("retire_status", status_o, t.st);
            end
        end
    end

    task automatic step();
        int idx;
        @(posedge clk_i);
        if (rec_rst || rec_flush) begin
            hq.delete();
            sb.delete();
            model_cnt = 0;
            for (int g = 0; g < NG; g++) begin
                gh[g] = 0;
                gn[g] = 0;
            end
        end else begin
            if (rec_pop && hq.size() > 0) begin
                hq.delete(0);
                model_cnt--;
            end
            if (rec_acc) begin
                hq.push_back(int'(rec_grp));
                sb.push_back(rec_tok);
                model_cnt++;
            end
            for (int g = 0; g < NG; g++) begin
                if (rec_gpop[g] && gn[g] > 0) begin
                    gh[g] = (gh[g] + 1) % 8;
                    gn[g]--;
                end
                if (rec_gacc[g]) begin
                    idx          = (gh[g] + gn[g]) % 8;
                    gres[g][idx] = rec_tok.res;
                    gst[g][idx]  = rec_tok.st;
                    grdy[g][idx] = cyc + lat[g];
                    gn[g]++;
                end
            end
        end
        cyc++;
        #1;
        for (int g = 0; g < NG; g++) begin
            if (gn[g] > 0) begin
                grp_out_valid_i[g]       = (grdy[g][gh[g]] <= cyc);
                grp_result_i[g*W +: W]   = gres[g][gh[g]];
                grp_status_i[g*5 +: 5]   = gst[g][gh[g]];
            end else begin
                grp_out_valid_i[g]       = 1'b0;
                grp_result_i[g*W +: W]   = $urandom;
                grp_status_i[g*5 +: 5]   = 5'($urandom);
            end
        end
    endtask

    task automatic issue(input int g, input logic [W-1:0] r, input logic [4:0] s);
        in_group_i = GW'(g);
        tok.res    = r;
        tok.st     = s;
        in_valid_i = 1'b1;
        step();
    endtask

    task automatic drain();
        in_valid_i     = 1'b0;
        out_ready_i    = 1'b1;
        flush_i        = 1'b0;
        rst_i          = 1'b0;
        grp_in_ready_i = '1;
        for (int i = 0; i < 80 && model_cnt > 0; i++) step();
        chk("drain_timeout", model_cnt, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst_i           = 1'b1;
        flush_i         = 1'b0;
        in_valid_i      = 1'b1;
        in_group_i      = '0;
        grp_in_ready_i  = '1;
        grp_out_valid_i = '0;
        grp_result_i    = '0;
        grp_status_i    = '0;
        out_ready_i     = 1'b1;
        tok             = '{res: 32'h0000_00A5, st: 5'h03};

        // Reset held for two edges with a request pending.
        step();
        step();
        rst_i = 1'b0;
        step();
        in_valid_i = 1'b0;
        #1;
        chk("first_accept_outstanding", outstanding_o, 1);
        drain();

        // Out-of-order completion: slow group 0 then fast group 1.
        issue(0, 32'h11, 5'h10);
        issue(1, 32'h22, 5'h01);
        in_valid_i = 1'b0;
        drain();

        // Full and wrap-around with the retire port stalled.
        out_ready_i = 1'b0;
        for (int i = 0; i < DEPTH + 1; i++) issue(int'($urandom_range(0, NG - 1)), $urandom, 5'($urandom));
        in_valid_i = 1'b0;
        #1;
        chk("full_outstanding", outstanding_o, DEPTH);
        for (int i = 0; i < 5; i++) step();
        out_ready_i = 1'b1;
        issue(1, 32'h5555, 5'h04);
        in_valid_i = 1'b0;
        #1;
        chk("pop_with_blocked_push", outstanding_o, DEPTH - 1);
        for (int i = 0; i < 12; i++) issue(int'($urandom_range(0, NG - 1)), $urandom, 5'($urandom));
        drain();

        // Flush with a valid head result.
        out_ready_i = 1'b0;
        for (int i = 0; i < 5; i++) issue(1, 32'h100 + 32'(i), 5'(i));
        in_valid_i = 1'b0;
        step();
        step();
        out_ready_i = 1'b1;
        flush_i     = 1'b1;
        step();
        flush_i = 1'b0;
        #1;
        chk("flush_outstanding", outstanding_o, 0);
        chk("flush_busy", busy_o, 0);
        drain();

        // Group input backpressure.
        grp_in_ready_i = 3'b011;
        issue(2, 32'h77, 5'h02);
        #1;
        chk("backpressure_no_write", outstanding_o, 0);
        issue(1, 32'h88, 5'h08);
        #1;
        chk("switch_group_accept", outstanding_o, 1);
        drain();

        // Downstream stall on a valid head.
        out_ready_i = 1'b0;
        issue(0, 32'hCAFE_0001, 5'h1F);
        in_valid_i = 1'b0;
        for (int i = 0; i < 10 && !grp_out_valid_i[0]; i++) step();
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("stall_out_valid", out_valid_o, 1);
            chk("stall_result", result_o, 32'hCAFE_0001);
            chk("stall_outstanding", outstanding_o, 1);
            step();
        end
        out_ready_i = 1'b1;
        step();
        #1;
        chk("stall_release_pop", outstanding_o, 0);

        // Randomized traffic including bad indices, flushes and resets.
        for (int i = 0; i < 500; i++) begin
            in_valid_i     = ($urandom_range(0, 9) < 7);
            in_group_i     = ($urandom_range(0, 19) == 0) ? 2'd3 : GW'($urandom_range(0, NG - 1));
            for (int g = 0; g < NG; g++) grp_in_ready_i[g] = ($urandom_range(0, 4) != 0);
            out_ready_i    = ($urandom_range(0, 3) != 0);
            flush_i        = ($urandom_range(0, 49) == 0);
            rst_i          = ($urandom_range(0, 99) == 0);
            tok.res        = $urandom;
            tok.st         = 5'($urandom);
            step();
        end
        drain();
        chk("scoreboard_empty", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
